// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - multi-port register file with write-through forwarding and clear engine
// Optional parity storage and error reporting under `define REGFILE_PARITY_EN.
module reg_file_mp #(
  parameter int ADW      = 5,
  parameter int DPW      = 32,
  parameter int NRP      = 2,
  parameter int NWP      = 1,
  parameter int ZERO_REG = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr_req,
  output logic               busy,
  input  logic [NRP-1:0]     rd_en,
  input  logic [NRP*ADW-1:0] rd_addr,
  output logic [NRP*DPW-1:0] rd_data,
  input  logic [NWP-1:0]     we,
  input  logic [NWP*ADW-1:0] wr_addr,
  input  logic [NWP*DPW-1:0] wr_data
`ifdef REGFILE_PARITY_EN
  ,
  input  logic [NWP-1:0]     wr_perr_inj,
  output logic [NRP-1:0]     rd_perr
`endif
);

  localparam int DEPTH = 1 << ADW;

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  state_t           state;
  logic [ADW-1:0]   cnt;
  logic [DPW-1:0]   mem [DEPTH];
  logic [NWP-1:0]   wr_ok;
  logic [NRP*DPW-1:0] rd_nxt;
`ifdef REGFILE_PARITY_EN
  logic             mem_par [DEPTH];
  logic [NRP-1:0]   rd_pnxt;
`endif

  // A write is effective only in IDLE and never to the hardwired zero entry.
  always_comb begin
    wr_ok = '0;
    for (int j = 0; j < NWP; j++) begin
      wr_ok[j] = we[j] && (state == S_IDLE) &&
                 !((ZERO_REG != 0) && (wr_addr[j*ADW +: ADW] == '0));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_CLEAR;
      cnt   <= '0;
      busy  <= 1'b1;
    end else begin
      case (state)
        S_CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == ADW'(DEPTH - 1)) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        S_IDLE: begin
          if (clr_req) begin
            state <= S_CLEAR;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        default: state <= S_CLEAR;
      endcase
    end
  end

  // Later ports overwrite earlier ones, so the highest-index writer wins.
  always_ff @(posedge clk) begin
    if (state == S_CLEAR) begin
      mem[cnt] <= '0;
`ifdef REGFILE_PARITY_EN
      mem_par[cnt] <= 1'b0;
`endif
    end else begin
      for (int j = 0; j < NWP; j++) begin
        if (wr_ok[j]) begin
          mem[wr_addr[j*ADW +: ADW]] <= wr_data[j*DPW +: DPW];
`ifdef REGFILE_PARITY_EN
          mem_par[wr_addr[j*ADW +: ADW]] <= (^wr_data[j*DPW +: DPW]) ^ wr_perr_inj[j];
`endif
        end
      end
    end
  end

  always_comb begin
    rd_nxt = '0;
`ifdef REGFILE_PARITY_EN
    rd_pnxt = '0;
`endif
    for (int i = 0; i < NRP; i++) begin
      logic [ADW-1:0] a;
      a = rd_addr[i*ADW +: ADW];
      if ((state == S_IDLE) && !((ZERO_REG != 0) && (a == '0))) begin
        rd_nxt[i*DPW +: DPW] = mem[a];
`ifdef REGFILE_PARITY_EN
        rd_pnxt[i] = (^mem[a]) ^ mem_par[a];
`endif
        for (int j = 0; j < NWP; j++) begin
          if (wr_ok[j] && (wr_addr[j*ADW +: ADW] == a)) begin
            rd_nxt[i*DPW +: DPW] = wr_data[j*DPW +: DPW];
`ifdef REGFILE_PARITY_EN
            // Forwarded parity mismatches exactly when the write injects an error.
            rd_pnxt[i] = wr_perr_inj[j];
`endif
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
`ifdef REGFILE_PARITY_EN
      rd_perr <= '0;
`endif
    end else begin
      for (int i = 0; i < NRP; i++) begin
        if (rd_en[i]) begin
          rd_data[i*DPW +: DPW] <= rd_nxt[i*DPW +: DPW];
`ifdef REGFILE_PARITY_EN
          rd_perr[i] <= rd_pnxt[i];
`endif
        end
      end
    end
  end

endmodule
